pc_step_controller: RTL and testbench

Front-end stage that turns the board's raw, bouncing active-low push-buttons into clean, single-cycle advance strobes for the program counter. Debounces a STEP key and a RUN key, and supports two modes: manual single-step (one strobe per press) and free-run (one strobe every RUN_PERIOD cycles). Sits between the KEY inputs and ProgramCounter. The whole design stays on the 50 MHz clock, with `step_en` used as PC clock-enable instead of a button-derived clock. Also provides a wrapping strobe count for LED display.

---
 rtl/pc_ctrl_pkg.sv | 22 ++
 rtl/key_debouncer.sv | 69 ++++++
 rtl/pc_step_controller.sv | 106 ++++++++++
 tb/tb_pc_step_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared definitions for the program-counter step controller:
//   - pc_state_e : controller mode (ST_STEP = 0, ST_RUN = 1)
//   - *_DEF      : board constants for a 50 MHz clock
//   - *_SIM      : short constants that keep simulations fast
// No ports (package).
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

   typedef enum logic {
      ST_STEP = 1'b0,
      ST_RUN  = 1'b1
   } pc_state_e;

   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;  // 20 ms at 50 MHz
   localparam int RUN_PERIOD_DEF      = 25_000_000; // 0.5 s at 50 MHz

   localparam int DEBOUNCE_CYCLES_SIM = 4;
   localparam int RUN_PERIOD_SIM      = 8;

endpackage

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// Cleans one raw active-low push-button: 2-FF synchronizer, stable-level
// counter and a registered one-cycle press pulse on a 1->0 debounced edge.
// Ports:
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   key_n      in  raw active-low key, asynchronous to clk
//   db_state   out debounced key level (1 = released)
//   press      out one-cycle pulse when the debounced level falls
// ---------------------------------------------------------------------------
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic db_state,
   output logic press
);

   localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          db_state_q, db_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   always_comb begin
      sync1_d    = key_n;
      sync2_d    = sync1_q;
      db_state_d = db_state_q;
      cnt_d      = '0;
      // The counter only runs while the synchronized level disagrees with
      // the accepted level; any agreeing sample restarts the qualification.
      if (sync2_q != db_state_q) begin
         if (cnt_q == CNT_MAX) begin
            db_state_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      // Pulse is registered alongside the debounced fall, so it is visible
      // in the same cycle db_state goes low.
      press_d = db_state_q & ~db_state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         db_state_q <= 1'b1;
         cnt_q      <= '0;
         press_q    <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_state_q <= db_state_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
      end
   end

   assign db_state = db_state_q;
   assign press    = press_q;

endmodule

// File: rtl/pc_step_controller.sv
// ---------------------------------------------------------------------------
// pc_step_controller
// Turns the STEP and RUN keys into single-cycle program-counter advance
// strobes. STEP mode: one strobe per STEP press. RUN mode: one strobe every
// RUN_PERIOD cycles. The RUN key toggles between the modes.
// Ports:
//   clk         in  system clock (CLOCK_50)
//   reset       in  synchronous active-high reset
//   key_step_n  in  raw STEP key, active-low
//   key_run_n   in  raw RUN/STOP key, active-low
//   step_en     out one-cycle PC clock-enable strobe
//   run_mode    out 1 = RUN mode, 0 = STEP mode (mirrors the FSM state)
//   step_count  out number of strobes issued, modulo 256
// ---------------------------------------------------------------------------
module pc_step_controller
   import pc_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int RUN_PERIOD      = RUN_PERIOD_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_step_n,
   input  logic       key_run_n,
   output logic       step_en,
   output logic       run_mode,
   output logic [7:0] step_count
);

   localparam int             PW       = $clog2(RUN_PERIOD);
   localparam logic [PW-1:0]  PCNT_MAX = PW'(RUN_PERIOD - 1);

   logic step_db, step_press;
   logic run_db,  run_press;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
      .clk      (clk),
      .reset    (reset),
      .key_n    (key_step_n),
      .db_state (step_db),
      .press    (step_press)
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
      .clk      (clk),
      .reset    (reset),
      .key_n    (key_run_n),
      .db_state (run_db),
      .press    (run_press)
   );

   pc_state_e     state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          step_en_q, step_en_d;
   logic          run_mode_q, run_mode_d;
   logic [7:0]    step_count_q, step_count_d;

   always_comb begin
      state_d   = state_q;
      pcnt_d    = '0;
      step_en_d = 1'b0;
      case (state_q)
         ST_STEP: begin
            // A RUN press takes priority over a simultaneous STEP press.
            if (run_press) begin
               state_d = ST_RUN;
            end else if (step_press) begin
               step_en_d = 1'b1;
            end
         end
         ST_RUN: begin
            // Leaving RUN on the terminal count suppresses that strobe.
            if (run_press) begin
               state_d = ST_STEP;
            end else begin
               step_en_d = (pcnt_q == PCNT_MAX);
               pcnt_d    = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + PW'(1);
            end
         end
         default: state_d = ST_STEP;
      endcase
      run_mode_d   = (state_d == ST_RUN);
      step_count_d = step_count_q + {7'b0, step_en_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_STEP;
         pcnt_q       <= '0;
         step_en_q    <= 1'b0;
         run_mode_q   <= 1'b0;
         step_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         pcnt_q       <= pcnt_d;
         step_en_q    <= step_en_d;
         run_mode_q   <= run_mode_d;
         step_count_q <= step_count_d;
      end
   end

   assign step_en    = step_en_q;
   assign run_mode   = run_mode_q;
   assign step_count = step_count_q;

endmodule

// File: tb/tb_pc_step_controller.sv
// ---------------------------------------------------------------------------
// tb_pc_step_controller
// Directed bench for pc_step_controller with DEBOUNCE_CYCLES=4, RUN_PERIOD=8.
// Inputs change 1 ns after a rising edge; outputs are sampled there too, so
// each sample reflects the edge just taken. A key driven low right after
// tick b is first sampled at edge b+1, so its press strobe (or mode change)
// appears after tick b+7 (debounce 4 + synchronizer 2 + event/FSM stages).
// ---------------------------------------------------------------------------
module tb_pc_step_controller;
   import pc_ctrl_pkg::*;

   logic       clk;
   logic       reset;
   logic       key_step_n;
   logic       key_run_n;
   logic       step_en;
   logic       run_mode;
   logic [7:0] step_count;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc     = 0;
   int pulse_q[$];            // cycle numbers at which step_en was seen high
   logic [31:0] exp_q[$];     // expected strobe cycles
   int b;

   pc_step_controller #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
      .RUN_PERIOD      (RUN_PERIOD_SIM)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_step_n (key_step_n),
      .key_run_n  (key_run_n),
      .step_en    (step_en),
      .run_mode   (run_mode),
      .step_count (step_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (step_en === 1'b1) pulse_q.push_back(cyc);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      key_step_n = 1'b1;
      key_run_n  = 1'b1;
      ticks(2);
      reset = 1'b0;
      pulse_q.delete();
   endtask

   // scoreboard check
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      key_step_n = 1'b1;
      key_run_n  = 1'b1;

      // ---- 1: reset state, single step press with exact latency ----
      do_reset();
      check("rst_step_en", {31'b0, step_en}, 0);
      check("rst_run_mode", {31'b0, run_mode}, 0);
      check("rst_count", {24'b0, step_count}, 0);
      key_step_n = 1'b0;
      b = cyc;
      ticks(20);
      check("t1_pulses_held", pulse_q.size(), 1);
      if (pulse_q.size() > 0) check("t1_latency", pulse_q[0] - b, 7);
      check("t1_count", {24'b0, step_count}, 1);
      key_step_n = 1'b1;
      ticks(20);
      check("t1_pulses_release", pulse_q.size(), 1);

      // ---- 2: bouncing key never qualifies ----
      do_reset();
      for (int j = 1; j <= 20; j++) begin
         key_step_n = (j % 2 == 1) ? 1'b0 : 1'b1;
         tick();
      end
      key_step_n = 1'b1;
      ticks(12);
      check("t2_pulses", pulse_q.size(), 0);
      check("t2_count", {24'b0, step_count}, 0);

      // ---- 3: RUN cadence, step presses ignored ----
      do_reset();
      exp_q.delete();
      b = cyc;
      for (int j = 1; j <= 48; j++) begin
         key_run_n  = (j <= 10) ? 1'b0 : 1'b1;
         key_step_n = (j >= 13 && j <= 24) ? 1'b0 : 1'b1;
         tick();
         if (j == 6) check("t3_run_mode_before", {31'b0, run_mode}, 0);
         if (j == 7) check("t3_run_mode_rise", {31'b0, run_mode}, 1);
      end
      for (int i = 0; i < 5; i++) exp_q.push_back(32'(b + 15 + 8 * i));
      check("t3_pulse_cnt", pulse_q.size(), 5);
      for (int i = 0; i < 5 && i < pulse_q.size(); i++)
         check($sformatf("t3_pulse%0d_cyc", i), pulse_q[i], exp_q[i]);
      check("t3_count", {24'b0, step_count}, 5);

      // ---- 4a: RUN press lands on terminal count: mode change, no strobe ----
      for (int j = 49; j <= 66; j++) begin
         key_run_n = (j <= 60) ? 1'b0 : 1'b1;
         tick();
         if (j == 54) check("t4_run_mode_hold", {31'b0, run_mode}, 1);
         if (j == 55) begin
            check("t4_run_mode_fall", {31'b0, run_mode}, 0);
            check("t4_no_strobe", {31'b0, step_en}, 0);
         end
      end
      check("t4_pulse_cnt", pulse_q.size(), 5);
      check("t4_count", {24'b0, step_count}, 5);

      // ---- 4b: both keys together in STEP: run wins, no strobe ----
      do_reset();
      key_step_n = 1'b0;
      key_run_n  = 1'b0;
      ticks(12);
      check("t4b_run_mode", {31'b0, run_mode}, 1);
      check("t4b_pulses", pulse_q.size(), 0);
      check("t4b_count", {24'b0, step_count}, 0);

      // ---- 5: 256 steps wrap the count ----
      do_reset();
      for (int n = 1; n <= 256; n++) begin
         key_step_n = 1'b0;
         ticks(8);
         key_step_n = 1'b1;
         ticks(8);
         if (n == 255) check("t5_count_255", {24'b0, step_count}, 255);
      end
      check("t5_count_wrap", {24'b0, step_count}, 0);
      check("t5_pulses", pulse_q.size(), 256);

      // ---- 6: reset mid-RUN at period count 5, held key re-debounces ----
      do_reset();
      key_run_n = 1'b0;
      b = cyc;
      ticks(20);
      check("t6_count_pre", {24'b0, step_count}, 1);
      check("t6_run_mode_pre", {31'b0, run_mode}, 1);
      reset = 1'b1;
      tick();
      check("t6_rst_step_en", {31'b0, step_en}, 0);
      check("t6_rst_run_mode", {31'b0, run_mode}, 0);
      check("t6_rst_count", {24'b0, step_count}, 0);
      tick();
      reset = 1'b0;
      pulse_q.delete();
      ticks(6);
      check("t6_redeb_early", {31'b0, run_mode}, 0);
      tick();
      check("t6_redeb_rise", {31'b0, run_mode}, 1);
      check("t6_redeb_pulses", pulse_q.size(), 0);
      key_run_n = 1'b1;
      ticks(4);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
